// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - registered 5-stage log barrel shifter (logical/rotate/arithmetic); optional zero flag via BARREL_SHIFTER_ZERO_FLAG_EN
module barrel_shifter #(
    parameter int N = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N:0]   in,
    input  logic [4:0]   sl,
    input  logic         left_of_right,
    input  logic [1:0]   logick_rotate_ariphmetic_shift,
    output logic [N:0]   out
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    localparam int W = N + 1;

    // Left shifts are done by bit-reversing the operand, shifting right,
    // and reversing the result back, so a single right-shifting network
    // serves both directions.
    logic         dir_right;
    logic         mode_rotate;
    logic         mode_arith;
    logic         fill_bit;

    logic [N:0]   in_rev;
    logic [N:0]   stg [0:5];
    logic [N:0]   res_rev;
    logic [N:0]   out_d;
    logic [N:0]   out_q;

    assign dir_right   = left_of_right;
    assign mode_rotate = (logick_rotate_ariphmetic_shift == 2'b01);
    assign mode_arith  = logick_rotate_ariphmetic_shift[1];

    // Sign extension only applies to arithmetic right shifts; arithmetic
    // left behaves as logical left and fills with zeros.
    assign fill_bit = mode_arith & dir_right & in[N];

    genvar gb;
    generate
        for (gb = 0; gb < W; gb++) begin : g_rev
            assign in_rev[gb]  = in[W-1-gb];
            assign res_rev[gb] = stg[5][W-1-gb];
        end
    endgenerate

    assign stg[0] = dir_right ? in : in_rev;

    // Stage k shifts right by 2**k when sl[k] is set. Bits entering at the
    // MSB end wrap around from the LSB end when rotating, otherwise they
    // take the fill bit.
    genvar gk, gi;
    generate
        for (gk = 0; gk < 5; gk++) begin : g_stage
            localparam int S = 1 << gk;
            for (gi = 0; gi < W; gi++) begin : g_bit
                if (gi + S < W) begin : g_inner
                    assign stg[gk+1][gi] = sl[gk] ? stg[gk][gi+S] : stg[gk][gi];
                end else begin : g_edge
                    assign stg[gk+1][gi] = sl[gk]
                                         ? (mode_rotate ? stg[gk][gi+S-W] : fill_bit)
                                         : stg[gk][gi];
                end
            end
        end
    endgenerate

    assign out_d = dir_right ? stg[5] : res_rev;

    // Output register: reset clears the result, otherwise capture the
    // combinational shift result of the inputs sampled on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    logic zero_d;
    logic zero_q;

    assign zero_d = (out_d == '0);

    // Zero flag registered alongside the result so both refer to the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_barrel_shifter.sv
// tb/tb_barrel_shifter.sv - directed self-checking bench for barrel_shifter (zero flag checked when BARREL_SHIFTER_ZERO_FLAG_EN is defined)
module tb_barrel_shifter;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic [4:0]  sl;
    logic        left_of_right;
    logic [1:0]  mode;
    logic [31:0] out;
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    logic        zero;
`endif

    int n_checks;
    int n_fail;

    barrel_shifter #(.N(31)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .in                             (in),
        .sl                             (sl),
        .left_of_right                  (left_of_right),
        .logick_rotate_ariphmetic_shift (mode),
        .out                            (out)
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
        ,
        .zero                           (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [4:0] s,
                                              input logic r, input logic [1:0] m);
        logic [63:0]        dbl;
        logic [63:0]        t;
        logic signed [31:0] sx;
        dbl = {x, x};
        sx  = x;
        if (m == 2'b01) begin
            if (r) begin
                t = dbl >> s;
                return t[31:0];
            end else begin
                t = dbl << s;
                return t[63:32];
            end
        end else if (m[1] && r) begin
            return sx >>> s;
        end else if (r) begin
            return x >> s;
        end else begin
            return x << s;
        end
    endfunction

    task automatic drive(input logic [31:0] x, input logic [4:0] s, input logic r, input logic [1:0] m);
        @(negedge clk);
        in            = x;
        sl            = s;
        left_of_right = r;
        mode          = m;
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (out === exp) else begin
            n_fail++;
            $error("FAIL %s: out=%h expected %h", tag, out, exp);
        end
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
        n_checks++;
        assert (zero === (exp == 32'h0)) else begin
            n_fail++;
            $error("FAIL %s_zero: zero=%b expected %b", tag, zero, (exp == 32'h0));
        end
`endif
    endtask

    task automatic step(input string tag, input logic [31:0] x, input logic [4:0] s,
                        input logic r, input logic [1:0] m, input logic [31:0] exp);
        drive(x, s, r, m);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        in = 32'hDEAD_BEEF;
        sl = 5'd3;
        left_of_right = 1'b0;
        mode = 2'b00;

        // Reset state: inputs ignored
        @(posedge clk);
        #1;
        check("reset", 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Logical
        step("lsl4",   32'hFFFF_0000, 5'd4,  1'b0, 2'b00, 32'hFFF0_0000);
        step("lsl0",   32'hFFFF_0000, 5'd0,  1'b0, 2'b00, 32'hFFFF_0000);
        step("lsr8",   32'hFFFF_0000, 5'd8,  1'b1, 2'b00, 32'h00FF_FF00);
        // Rotate
        step("ror4",   32'h7FFF_000A, 5'd4,  1'b1, 2'b01, 32'hA7FF_F000);
        step("rol8",   32'hFFFF_0000, 5'd8,  1'b0, 2'b01, 32'hFF00_00FF);
        // Arithmetic
        step("asr4",   32'hFFFF_0000, 5'd4,  1'b1, 2'b10, 32'hFFFF_F000);
        step("asl4",   32'h7FFF_0000, 5'd4,  1'b0, 2'b11, 32'hFFF0_0000);
        step("asr4_p", 32'h7FFF_0000, 5'd4,  1'b1, 2'b11, 32'h07FF_F000);
        // sl = 31 boundaries
        step("lsl31",  32'h0000_0003, 5'd31, 1'b0, 2'b00, 32'h8000_0000);
        step("lsr31",  32'hC000_0000, 5'd31, 1'b1, 2'b00, 32'h0000_0001);
        step("asr31",  32'h8000_0000, 5'd31, 1'b1, 2'b10, 32'hFFFF_FFFF);
        step("rol31",  32'h0000_0003, 5'd31, 1'b0, 2'b01, 32'h8000_0001);
        step("ror31",  32'h8000_0001, 5'd31, 1'b1, 2'b01, 32'h0000_0003);
        step("ror0",   32'h1234_5678, 5'd0,  1'b1, 2'b01, 32'h1234_5678);
        step("lsr1_z", 32'h0000_0001, 5'd1,  1'b1, 2'b00, 32'h0000_0000);

        // Input changes between edges do not reach out
        step("hold_a", 32'h0000_00F0, 5'd4,  1'b0, 2'b00, 32'h0000_0F00);
        #2;
        in = 32'hFFFF_FFFF;
        sl = 5'd0;
        #1;
        check("hold_b", 32'h0000_0F00);

        // Reset mid-stream discards the in-flight result
        drive(32'h0000_0F0F, 5'd4, 1'b0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst", 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst", 32'h0000_F0F0);

        // Sweep every shift amount, direction and mode against the model
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < 2; r++) begin
                for (int s = 0; s < 32; s++) begin
                    step("sweep", 32'h8C3A_5E71, s[4:0], r[0], m[1:0],
                         ref_model(32'h8C3A_5E71, s[4:0], r[0], m[1:0]));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
